// File: rtl/dmem_port_arbiter_pkg.sv
// ============================================================================
// Module  : dmem_port_arbiter_pkg
// Brief   : State encodings, owner type and helpers shared by the DataMemory
//           port arbiter and its round-robin picker.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_port_arbiter_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_OWN_CPU = 2'd1;
    localparam logic [1:0] ST_OWN_LDR = 2'd2;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_LDR = 1'b1
    } owner_e;

    function automatic owner_e other_owner(input owner_e i_owner);
        return (i_owner == OWNER_CPU) ? OWNER_LDR : OWNER_CPU;
    endfunction

    function automatic logic [1:0] owner_state(input owner_e i_owner);
        return (i_owner == OWNER_CPU) ? ST_OWN_CPU : ST_OWN_LDR;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_port_arbiter_if.sv
// ============================================================================
// Module  : dmem_port_arbiter_if
// Brief   : Single-beat requester bus for one DataMemory port client.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

`default_nettype wire

// File: rtl/dmem_port_arbiter_arb_rr_pick.sv
// ============================================================================
// Module  : arb_rr_pick
// Brief   : Combinational winner picker for an idle port: round-robin on a
//           tie, or CPU-first when fixed priority is enabled.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_rr_pick
    import dmem_port_arbiter_pkg::*;
(
    input  wire    i_req_cpu,
    input  wire    i_req_ldr,
    input  wire    i_prio_en,
    input  owner_e i_last_owner,
    output logic   o_valid,
    output owner_e o_winner
);

    always_comb begin
        o_valid  = i_req_cpu | i_req_ldr;
        o_winner = OWNER_CPU;
        if (i_req_cpu && i_req_ldr) begin
            o_winner = i_prio_en ? OWNER_CPU : other_owner(i_last_owner);
        end else if (i_req_ldr) begin
            o_winner = OWNER_LDR;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
// ============================================================================
// Module  : dmem_port_arbiter
// Brief   : Shares the DataMemory port between the CPU and the debug loader.
//           Define DMEM_ARB_CPU_PRIO_EN for fixed CPU priority.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int HOLD_MAX = 4
) (
    input  wire               clk,
    input  wire               rst_n,
    dmem_port_arbiter_if.slave cpu,
    dmem_port_arbiter_if.slave ldr,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_we,
    output logic              o_mem_re,
    input  wire  [DATA_W-1:0] i_mem_rdata
);

    localparam int CNT_W = $clog2(HOLD_MAX + 1);

`ifdef DMEM_ARB_CPU_PRIO_EN
    localparam logic c_prio_en = 1'b1;
`else
    localparam logic c_prio_en = 1'b0;
`endif

    logic [1:0]       r_state;
    owner_e           r_last_owner;
    logic [CNT_W-1:0] r_beat_cnt;
    logic             r_cpu_rvalid;
    logic             r_ldr_rvalid;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_ldr_rdata;

    logic [1:0]       w_state_nxt;
    owner_e           w_last_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_sat;
    logic             w_cnt_below;
    logic             w_hold_ok;
    logic             w_gnt_cpu;
    logic             w_gnt_ldr;
    owner_e           w_cur_owner;
    logic             w_own_req;
    logic             w_oth_req;
    logic             w_pick_valid;
    owner_e           w_pick_winner;

    arb_rr_pick u_pick (
        .i_req_cpu    (cpu.req),
        .i_req_ldr    (ldr.req),
        .i_prio_en    (c_prio_en),
        .i_last_owner (r_last_owner),
        .o_valid      (w_pick_valid),
        .o_winner     (w_pick_winner)
    );

    // Grants come from the state register alone so reset removes them at once.
    assign w_gnt_cpu   = (r_state == ST_OWN_CPU);
    assign w_gnt_ldr   = (r_state == ST_OWN_LDR);
    assign w_cur_owner = w_gnt_ldr ? OWNER_LDR : OWNER_CPU;
    assign w_own_req   = w_gnt_ldr ? ldr.req : cpu.req;
    assign w_oth_req   = w_gnt_ldr ? cpu.req : ldr.req;

    assign w_cnt_below = (int'(r_beat_cnt) + 1) < HOLD_MAX;
    assign w_cnt_sat   = w_cnt_below ? (r_beat_cnt + CNT_W'(1)) : r_beat_cnt;
    assign w_hold_ok   = w_cnt_below | (c_prio_en & w_gnt_cpu);

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last_owner;
        w_cnt_nxt   = r_beat_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = owner_state(w_pick_winner);
                    w_cnt_nxt   = '0;
                end
            end
            ST_OWN_CPU, ST_OWN_LDR: begin
                w_last_nxt = w_cur_owner;
                if (w_own_req && (!w_oth_req || w_hold_ok)) begin
                    w_cnt_nxt = w_cnt_sat;
                end else if (w_oth_req) begin
                    w_state_nxt = owner_state(other_owner(w_cur_owner));
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last_owner <= OWNER_LDR;
            r_beat_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_owner <= w_last_nxt;
            r_beat_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cpu_rvalid <= 1'b0;
            r_ldr_rvalid <= 1'b0;
            r_cpu_rdata  <= '0;
            r_ldr_rdata  <= '0;
        end else begin
            r_cpu_rvalid <= w_gnt_cpu & ~cpu.we;
            r_ldr_rvalid <= w_gnt_ldr & ~ldr.we;
            if (w_gnt_cpu && !cpu.we) begin
                r_cpu_rdata <= i_mem_rdata;
            end
            if (w_gnt_ldr && !ldr.we) begin
                r_ldr_rdata <= i_mem_rdata;
            end
        end
    end

    always_comb begin
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_we    = 1'b0;
        o_mem_re    = 1'b0;
        if (w_gnt_cpu) begin
            o_mem_addr  = cpu.addr;
            o_mem_wdata = cpu.wdata;
            o_mem_we    = cpu.we;
            o_mem_re    = ~cpu.we;
        end else if (w_gnt_ldr) begin
            o_mem_addr  = ldr.addr;
            o_mem_wdata = ldr.wdata;
            o_mem_we    = ldr.we;
            o_mem_re    = ~ldr.we;
        end
    end

    assign cpu.gnt    = w_gnt_cpu;
    assign cpu.rvalid = r_cpu_rvalid;
    assign cpu.rdata  = r_cpu_rdata;
    assign ldr.gnt    = w_gnt_ldr;
    assign ldr.rvalid = r_ldr_rvalid;
    assign ldr.rdata  = r_ldr_rdata;

endmodule

`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
// ============================================================================
// Module  : tb_dmem_port_arbiter
// Brief   : Scoreboard bench for dmem_port_arbiter with a small DataMemory
//           model; honours DMEM_ARB_CPU_PRIO_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        o_mem_we;
    logic        o_mem_re;
    logic [31:0] i_mem_rdata;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int          cyc;
        bit          ldr;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } gnt_t;

    typedef struct {
        int          cyc;
        bit          ldr;
        logic [31:0] data;
    } rd_t;

    gnt_t gq[$];
    rd_t  rq[$];

    dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) cpu_if ();
    dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ldr_if ();

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .HOLD_MAX(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cpu         (cpu_if),
        .ldr         (ldr_if),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_mem_we    (o_mem_we),
        .o_mem_re    (o_mem_re),
        .i_mem_rdata (i_mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // DataMemory model: preloaded words until first written.
    logic [31:0] mem [0:15];
    logic [15:0] mem_vld = '0;

    function automatic logic [31:0] mem_init(input logic [3:0] idx);
        case (idx)
            4'd4:    return 32'hDEAD_BEEF;
            4'd5:    return 32'h1111_1111;
            4'd12:   return 32'h1234_5678;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem_vld[a[5:2]] ? mem[a[5:2]] : mem_init(a[5:2]);
    endfunction

    assign i_mem_rdata = mem_rd(o_mem_addr);

    always @(posedge clk) begin
        if (o_mem_we) begin
            mem[o_mem_addr[5:2]]     <= o_mem_wdata;
            mem_vld[o_mem_addr[5:2]] <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_gnt(input int c, input bit l, input bit w, input logic [31:0] a, input logic [31:0] d);
        gnt_t g;
        g.cyc = c; g.ldr = l; g.we = w; g.addr = a; g.wdata = d;
        gq.push_back(g);
    endtask

    task automatic push_rd(input int c, input bit l, input logic [31:0] d);
        rd_t r;
        r.cyc = c; r.ldr = l; r.data = d;
        rq.push_back(r);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a grant or read data.
    always @(negedge clk) begin
        gnt_t g;
        rd_t  r;
        if (rst_n) begin
            if (cpu_if.gnt || ldr_if.gnt) begin
                if (gq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_gnt: got cpu=%b ldr=%b expected none (cycle %0d)",
                             cpu_if.gnt, ldr_if.gnt, cyc);
                end else begin
                    g = gq.pop_front();
                    chk("gnt_cycle", 64'(cyc), 64'(g.cyc));
                    chk("gnt_owner", {62'd0, cpu_if.gnt, ldr_if.gnt}, g.ldr ? 64'd1 : 64'd2);
                    chk("mem_bus", {o_mem_addr, o_mem_wdata}, {g.addr, g.wdata});
                    chk("mem_ctl", {62'd0, o_mem_we, o_mem_re}, {62'd0, g.we, ~g.we});
                end
            end
            if (cpu_if.rvalid) begin
                if (rq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_cpu_rvalid: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    r = rq.pop_front();
                    chk("cpu_rvalid_who", 64'(r.ldr), 64'd0);
                    chk("cpu_rvalid_cycle", 64'(cyc), 64'(r.cyc));
                    chk("cpu_rdata", 64'(cpu_if.rdata), 64'(r.data));
                end
            end
            if (ldr_if.rvalid) begin
                if (rq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ldr_rvalid: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    r = rq.pop_front();
                    chk("ldr_rvalid_who", 64'(r.ldr), 64'd1);
                    chk("ldr_rvalid_cycle", 64'(cyc), 64'(r.cyc));
                    chk("ldr_rdata", 64'(ldr_if.rdata), 64'(r.data));
                end
            end
        end
    end

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ctl"}, {58'd0, cpu_if.gnt, cpu_if.rvalid, ldr_if.gnt, ldr_if.rvalid, o_mem_we, o_mem_re}, 64'd0);
        chk({tag, "_rdata"}, {cpu_if.rdata, ldr_if.rdata}, 64'd0);
        chk({tag, "_membus"}, {o_mem_addr, o_mem_wdata}, 64'd0);
    endtask

    initial begin
        int c0;
        cpu_if.req = 1'b0; cpu_if.we = 1'b0; cpu_if.addr = '0; cpu_if.wdata = '0;
        ldr_if.req = 1'b0; ldr_if.we = 1'b0; ldr_if.addr = '0; ldr_if.wdata = '0;

        // Reset state, then a single CPU read of 0xDEADBEEF.
        step(2);
        chk_outputs_zero("in_reset");
        rst_n = 1'b1;
        step(1);
        chk_outputs_zero("after_reset");
        c0 = cyc;
        cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 32'h10;
        push_gnt(c0 + 1, 1'b0, 1'b0, 32'h10, 32'h0);
        push_rd(c0 + 2, 1'b0, 32'hDEAD_BEEF);
        step(1);
        cpu_if.req = 1'b0;
        step(3);
        chk("cpu_rdata_hold", 64'(cpu_if.rdata), 64'hDEAD_BEEF);

        // Both requesting from a fresh reset.
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(1);
        c0 = cyc;
        cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 32'h10;
        ldr_if.req = 1'b1; ldr_if.we = 1'b0; ldr_if.addr = 32'h14;
`ifdef DMEM_ARB_CPU_PRIO_EN
        for (int k = 1; k <= 8; k++) begin
            push_gnt(c0 + k, 1'b0, 1'b0, 32'h10, 32'h0);
            push_rd(c0 + k + 1, 1'b0, 32'hDEAD_BEEF);
        end
        push_gnt(c0 + 9, 1'b1, 1'b0, 32'h14, 32'h0);
        push_rd(c0 + 10, 1'b1, 32'h1111_1111);
        step(8);
        cpu_if.req = 1'b0;
        step(1);
        ldr_if.req = 1'b0;
        step(3);
`else
        for (int k = 1; k <= 12; k++) begin
            if (k >= 5 && k <= 8) begin
                push_gnt(c0 + k, 1'b1, 1'b0, 32'h14, 32'h0);
                push_rd(c0 + k + 1, 1'b1, 32'h1111_1111);
            end else begin
                push_gnt(c0 + k, 1'b0, 1'b0, 32'h10, 32'h0);
                push_rd(c0 + k + 1, 1'b0, 32'hDEAD_BEEF);
            end
        end
        step(12);
        cpu_if.req = 1'b0;
        ldr_if.req = 1'b0;
        step(3);
`endif

        // Loader write 0xAA to 0x20, then CPU read-back.
        c0 = cyc;
        ldr_if.req = 1'b1; ldr_if.we = 1'b1; ldr_if.addr = 32'h20; ldr_if.wdata = 32'h0000_00AA;
        push_gnt(c0 + 1, 1'b1, 1'b1, 32'h20, 32'h0000_00AA);
        step(1);
        ldr_if.req = 1'b0;
        step(1);
        c0 = cyc;
        cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 32'h20; cpu_if.wdata = 32'h0;
        push_gnt(c0 + 1, 1'b0, 1'b0, 32'h20, 32'h0);
        push_rd(c0 + 2, 1'b0, 32'h0000_00AA);
        step(1);
        cpu_if.req = 1'b0;
        step(3);
        chk("cpu_rdata_after_ldr_write", 64'(cpu_if.rdata), 64'h0000_00AA);

        // Reset asserted in the middle of a loader write grant.
        c0 = cyc;
        ldr_if.req = 1'b1; ldr_if.we = 1'b1; ldr_if.addr = 32'h30; ldr_if.wdata = 32'h0000_0055;
        push_gnt(c0 + 1, 1'b1, 1'b1, 32'h30, 32'h0000_0055);
        step(1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        ldr_if.req = 1'b0;
        #1;
        chk("rst_midbeat_we", {62'd0, o_mem_we, ldr_if.gnt}, 64'd0);
        step(1);
        chk("rst_midbeat_mem", 64'(mem_rd(32'h30)), 64'h1234_5678);
        chk_outputs_zero("midbeat_reset");
        rst_n = 1'b1;
        step(3);

        chk("gnt_queue_drained", 64'(gq.size()), 64'd0);
        chk("rd_queue_drained", 64'(rq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
